// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. It computes data_x - data_y one bit per
// clock, LSB first, and keeps the borrow in a register. An operation takes
// WIDTH busy cycles, followed by one cycle with done high. The next start can
// be accepted on the edge after that, which gives one operation every
// WIDTH+2 cycles.
//
// Parameters
//   WIDTH  operand and result width in bits (>= 2)
//   CNT_W  bit-counter width; 2**CNT_W must exceed WIDTH
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset (wins over everything)
//   start       in   request a new subtraction; sampled only in IDLE
//   data_x      in   minuend, unsigned; captured when start is accepted
//   data_y      in   subtrahend, unsigned; captured when start is accepted
//   busy        out  high while bits are being shifted (SHIFT state)
//   done        out  one-cycle pulse; result valid
//   dataOut     out  (data_x - data_y) mod 2**WIDTH; held until next done
//   borrow_out  out  1 when data_x < data_y; held together with dataOut
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_x,
  input  logic [WIDTH-1:0] data_y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic             borrow_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Counter value seen on the edge that handles the MSB.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;

  logic [WIDTH-1:0]   r_x_sr;
  logic [WIDTH-1:0]   r_y_sr;
  logic [WIDTH-1:0]   r_r_sr;
  logic               r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dout;
  logic               r_bout;

  logic               w_accept;
  logic               w_shift;
  logic               w_last;
  logic               w_diff_bit;
  logic               w_borrow_nxt;
  logic [WIDTH-1:0]   w_r_sr_nxt;

  // Full-subtractor cell: difference bit and outgoing borrow.
  function automatic logic diff_bit(input logic x, input logic y, input logic b);
    return x ^ y ^ b;
  endfunction

  function automatic logic borrow_bit(input logic x, input logic y, input logic b);
    return (~x & y) | (~(x ^ y) & b);
  endfunction

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_shift      = (r_state == S_SHIFT);
  assign w_last       = w_shift && (r_cnt == LAST_CNT);
  assign w_diff_bit   = diff_bit(r_x_sr[0], r_y_sr[0], r_b);
  assign w_borrow_nxt = borrow_bit(r_x_sr[0], r_y_sr[0], r_b);
  // New difference bits enter at the MSB, so after WIDTH shifts the LSB
  // computed first has reached bit 0.
  assign w_r_sr_nxt   = {w_diff_bit, r_r_sr[WIDTH-1:1]};

  // ---- control: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // ---- control: next state and next registered outputs ----
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start) begin
          w_state_nxt = S_SHIFT;
          w_busy_nxt  = 1'b1;
        end
      end
      S_SHIFT: begin
        w_busy_nxt = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // ---- datapath: shift registers, borrow, counter and result ----
  // Reset clears the datapath too, so an aborted operation never leaks a
  // partial result onto dataOut.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_sr <= '0;
      r_y_sr <= '0;
      r_r_sr <= '0;
      r_b    <= 1'b0;
      r_cnt  <= '0;
      r_dout <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_x_sr <= data_x;
      r_y_sr <= data_y;
      r_r_sr <= '0;
      r_b    <= 1'b0;
      r_cnt  <= '0;
    end else if (w_shift) begin
      r_x_sr <= {1'b0, r_x_sr[WIDTH-1:1]};
      r_y_sr <= {1'b0, r_y_sr[WIDTH-1:1]};
      r_r_sr <= w_r_sr_nxt;
      r_b    <= w_borrow_nxt;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_dout <= w_r_sr_nxt;
        r_bout <= w_borrow_nxt;
      end
    end
  end

  // ---- outputs ----
  assign busy       = r_busy;
  assign done       = r_done;
  assign dataOut    = r_dout;
  assign borrow_out = r_bout;

endmodule
